dmem_mmio: RTL and testbench

Data-side responder for the rv32im core: it serves the core's M-stage memory port with a byte-enabled data RAM and a small memory-mapped peripheral region. The peripheral region has a transmit byte FIFO with a valid/ready output stream, a 64-bit machine timer with compare interrupt, and a sticky tohost/halt register for simulation. Reads are combinational, so the core's writeback register captures ReadData at the end of the M cycle. Writes commit on the rising clock edge.

---
 rtl/dmem_mmio.sv | 245 ++++++++++++++++++++++++
 tb/tb_dmem_mmio.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio -- data-side responder for the rv32im core's M-stage memory port.
//
// Serves a byte-enabled data RAM at the bottom of the address space and a 4 KiB
// peripheral page at MMIO_BASE. The page holds:
//   0x00 TXDATA       write pushes a byte into the transmit FIFO
//   0x04 TXSTAT       {count, 13'b0, ovf, empty, full}; W1C on bit 2 (ovf)
//   0x08/0x0C MTIME   free-running 64-bit timer, byte-lane writable
//   0x10/0x14 MTIMECMP compare value for timer_irq
//   0x18 TOHOST       sticky halt flag plus last written value
// Reads are combinational from the current state. Writes commit on the edge.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   MemWrite, byte_en     store strobe and byte lanes from the core
//   ALUResult, WriteData  byte address and lane-aligned store data
//   ReadData              aligned word at ALUResult (combinational)
//   tx_valid/tx_ready/tx_data  transmit byte stream out of the FIFO
//   timer_irq             registered mtime >= mtimecmp
//   halt, tohost          simulation stop flag and its payload
// -----------------------------------------------------------------------------
module dmem_mmio #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned TX_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [3:0]  byte_en,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        timer_irq,
  output logic        halt,
  output logic [31:0] tohost
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TXDATA,
    SEL_TXSTAT,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TOHOST
  } mmio_sel_e;

  // Replace the enabled byte lanes of old_v with those of new_v.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          in_ram;
  logic          in_mmio;
  logic [AW-1:0] ram_idx;
  mmio_sel_e     sel;
  logic [1:0]    unused_addr_bits;

  assign in_ram           = (ALUResult[31:AW+2] == '0);
  assign in_mmio          = !in_ram && (ALUResult[31:12] == MMIO_BASE[31:12]);
  assign ram_idx          = ALUResult[AW+1:2];
  assign unused_addr_bits = ALUResult[1:0];

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sel = SEL_NONE;
    if (in_mmio) begin
      case (ALUResult[11:2])
        10'h000: sel = SEL_TXDATA;
        10'h001: sel = SEL_TXSTAT;
        10'h002: sel = SEL_MTIME_LO;
        10'h003: sel = SEL_MTIME_HI;
        10'h004: sel = SEL_CMP_LO;
        10'h005: sel = SEL_CMP_HI;
        10'h006: sel = SEL_TOHOST;
        default: sel = SEL_NONE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Data RAM
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH];
  logic        ram_we;

  assign ram_we = MemWrite && in_ram && !reset;

  // NOTE: the RAM array has no reset branch; clearing it would force a
  // flop-based implementation instead of a RAM macro, and software owns it.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_q[ram_idx][8*i +: 8] <= WriteData[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_q [TX_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          fifo_full, fifo_empty;
  logic          pop, push_req, push_ok;

  assign fifo_full  = (count_q == CW'(TX_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign tx_valid   = !fifo_empty;
  assign tx_data    = tx_valid ? fifo_q[rd_ptr_q] : 8'h00;

  assign pop      = tx_valid && tx_ready;
  assign push_req = MemWrite && (sel == SEL_TXDATA) && byte_en[0];
  // A full FIFO still accepts the byte when the head leaves in the same cycle.
  assign push_ok  = push_req && (!fifo_full || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) ovf_d = 1'b1;
    if (MemWrite && (sel == SEL_TXSTAT) && byte_en[0] && WriteData[2]) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) fifo_q[wr_ptr_q] <= WriteData[7:0];
  end

  // ---------------------------------------------------------------------------
  // Timer and TOHOST
  // ---------------------------------------------------------------------------
  logic [63:0] mtime_q,    mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] tohost_q,   tohost_d;
  logic        halt_q,     halt_d;
  logic        irq_q;

  always_comb begin
    // The increment is the base value; a write overrides only its lanes, and
    // the untouched lanes of the written half keep the incremented value.
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    tohost_d   = tohost_q;
    halt_d     = halt_q;
    if (MemWrite) begin
      case (sel)
        SEL_MTIME_LO: mtime_d[31:0]     = merge_lanes(mtime_d[31:0],     WriteData, byte_en);
        SEL_MTIME_HI: mtime_d[63:32]    = merge_lanes(mtime_d[63:32],    WriteData, byte_en);
        SEL_CMP_LO:   mtimecmp_d[31:0]  = merge_lanes(mtimecmp_q[31:0],  WriteData, byte_en);
        SEL_CMP_HI:   mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], WriteData, byte_en);
        SEL_TOHOST: begin
          tohost_d = merge_lanes(tohost_q, WriteData, byte_en);
          halt_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      tohost_q   <= '0;
      halt_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      tohost_q   <= tohost_d;
      halt_q     <= halt_d;
      // Compare the registered values, so the irq lags the compare by a cycle.
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  assign timer_irq = irq_q;
  assign halt      = halt_q;
  assign tohost    = tohost_q;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [15:0] count16;
  assign count16 = 16'(count_q);

  always_comb begin
    ReadData = '0;
    if (in_ram) begin
      ReadData = mem_q[ram_idx];
    end else begin
      case (sel)
        SEL_TXSTAT:   ReadData = {count16, 13'b0, ovf_q, fifo_empty, fifo_full};
        SEL_MTIME_LO: ReadData = mtime_q[31:0];
        SEL_MTIME_HI: ReadData = mtime_q[63:32];
        SEL_CMP_LO:   ReadData = mtimecmp_q[31:0];
        SEL_CMP_HI:   ReadData = mtimecmp_q[63:32];
        SEL_TOHOST:   ReadData = tohost_q;
        default:      ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio -- self-checking bench for dmem_mmio (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_dmem_mmio;

  localparam logic [31:0] TXDATA   = 32'h8000_0000;
  localparam logic [31:0] TXSTAT   = 32'h8000_0004;
  localparam logic [31:0] MTIME_LO = 32'h8000_0008;
  localparam logic [31:0] MTIME_HI = 32'h8000_000C;
  localparam logic [31:0] CMP_LO   = 32'h8000_0010;
  localparam logic [31:0] CMP_HI   = 32'h8000_0014;
  localparam logic [31:0] TOHOST   = 32'h8000_0018;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [3:0]  byte_en;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        timer_irq;
  logic        halt;
  logic [31:0] tohost;

  int n_checks = 0;
  int n_errors = 0;

  dmem_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .byte_en   (byte_en),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .timer_irq (timer_irq),
    .halt      (halt),
    .tohost    (tohost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  typedef struct {
    logic        do_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rd_addr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic do_wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [31:0] rd_addr, input logic [31:0] exp,
                     input string name);
    vec_t v;
    v.do_wr = do_wr; v.addr = addr; v.wdata = wdata; v.be = be;
    v.rd_addr = rd_addr; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ALUResult = a;
    WriteData = d;
    byte_en   = be;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
    byte_en   = 4'h0;
    WriteData = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    ALUResult = a;
    #1;
    r = ReadData;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] r;
  logic [7:0]  drain_exp [4];

  initial begin
    reset     = 1'b1;
    MemWrite  = 1'b0;
    byte_en   = 4'h0;
    ALUResult = '0;
    WriteData = '0;
    tx_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // ---- reset state ----
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_timer_irq", timer_irq, 0);
    check("rst_halt", halt, 0);
    check("rst_tohost", tohost, 0);
    rd(TXSTAT, r);
    check("rst_txstat", r, 32'h0000_0002);

    // ---- table-driven read/write vectors ----
    add(0, '0, '0, 4'h0, CMP_LO, 32'hFFFF_FFFF, "cmp_lo_reset");
    add(0, '0, '0, 4'h0, CMP_HI, 32'hFFFF_FFFF, "cmp_hi_reset");
    add(1, 32'h10, 32'hAABB_CCDD, 4'hF, 32'h10, 32'hAABB_CCDD, "ram_full_word");
    add(1, 32'h10, 32'h0000_0011, 4'h1, 32'h10, 32'hAABB_CC11, "ram_lane0");
    add(1, 32'h10, 32'h2200_0000, 4'h8, 32'h10, 32'h22BB_CC11, "ram_lane3");
    add(0, '0, '0, 4'h0, 32'h13, 32'h22BB_CC11, "ram_low_bits_ignored");
    add(1, 32'h0, 32'h1234_5678, 4'hF, 32'h0, 32'h1234_5678, "ram_word0");
    add(1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 32'h1000, 32'h0, "above_ram_reads_0");
    add(0, '0, '0, 4'h0, 32'h0, 32'h1234_5678, "no_alias_word0");
    add(1, 32'h8000_001C, 32'hFFFF_FFFF, 4'hF, 32'h8000_001C, 32'h0, "mmio_hole");
    add(1, CMP_LO, 32'h0000_1234, 4'h3, CMP_LO, 32'hFFFF_1234, "cmp_lo_lanes");
    add(1, CMP_HI, 32'hAB00_0000, 4'h8, CMP_HI, 32'hABFF_FFFF, "cmp_hi_lane3");
    add(1, 32'h4000_0000, 32'h1, 4'hF, 32'h4000_0000, 32'h0, "unmapped");
    add(0, '0, '0, 4'h0, TXDATA, 32'h0, "txdata_reads_0");
    add(0, '0, '0, 4'h0, 32'h8000_1008, 32'h0, "outside_mmio_page");

    foreach (vecs[i]) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      else tick();
      rd(vecs[i].rd_addr, r);
      check(vecs[i].name, r, vecs[i].exp);
    end
    tick();

    // ---- same-cycle read during a write sees the old word ----
    ALUResult = 32'h10;
    WriteData = 32'h0;
    byte_en   = 4'hF;
    MemWrite  = 1'b1;
    #1;
    check("same_cycle_old", ReadData, 32'h22BB_CC11);
    tick();
    MemWrite = 1'b0;
    byte_en  = 4'h0;
    rd(32'h10, r);
    check("after_write_new", r, 32'h0);

    // ---- FIFO fill with overflow ----
    tx_ready  = 1'b0;
    ALUResult = TXDATA;
    WriteData = 32'h41;
    byte_en   = 4'h1;
    MemWrite  = 1'b1;
    #1;
    check("no_fallthrough", tx_valid, 0);
    tick();
    MemWrite = 1'b0;
    check("push_visible_valid", tx_valid, 1);
    check("push_visible_data", tx_data, 8'h41);
    for (int i = 1; i < 5; i++) wr(TXDATA, 32'h41 + i, 4'h1);
    rd(TXSTAT, r);
    check("fill_txstat", r, 32'h0004_0005);
    check("fill_head", tx_data, 8'h41);

    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", tx_valid, 1);
      check("drain_data", tx_data, 8'h41 + i);
      tick();
    end
    check("drained_valid", tx_valid, 0);
    tx_ready = 1'b0;
    rd(TXSTAT, r);
    check("drained_txstat", r, 32'h0000_0006);

    wr(TXSTAT, 32'h4, 4'h1);
    rd(TXSTAT, r);
    check("w1c_ovf", r, 32'h0000_0002);

    // ---- full FIFO plus simultaneous pop accepts the push ----
    for (int i = 0; i < 4; i++) wr(TXDATA, 32'h50 + i, 4'h1);
    rd(TXSTAT, r);
    check("refill_txstat", r, 32'h0004_0001);
    tx_ready = 1'b1;
    wr(TXDATA, 32'h55, 4'h1);
    tx_ready = 1'b0;
    rd(TXSTAT, r);
    check("push_pop_txstat", r, 32'h0004_0001);
    check("push_pop_head", tx_data, 8'h51);

    drain_exp[0] = 8'h51; drain_exp[1] = 8'h52; drain_exp[2] = 8'h53; drain_exp[3] = 8'h55;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain2_data", tx_data, drain_exp[i]);
      tick();
    end
    check("drain2_empty", tx_valid, 0);
    tx_ready = 1'b0;

    // ---- reset mid-stream, concurrent push loses to reset ----
    for (int i = 0; i < 3; i++) wr(TXDATA, 32'h61 + i, 4'h1);
    check("queued_valid", tx_valid, 1);
    reset     = 1'b1;
    ALUResult = TXDATA;
    WriteData = 32'h77;
    byte_en   = 4'h1;
    MemWrite  = 1'b1;
    tick();
    reset    = 1'b0;
    MemWrite = 1'b0;
    byte_en  = 4'h0;
    check("rst_mid_valid", tx_valid, 0);
    check("rst_mid_data", tx_data, 0);
    rd(TXSTAT, r);
    check("rst_mid_txstat", r, 32'h0000_0002);
    rd(32'h0, r);
    check("ram_kept_over_reset", r, 32'h1234_5678);

    // ---- TOHOST / halt ----
    wr(TOHOST, 32'h1, 4'hF);
    check("halt_set", halt, 1);
    check("tohost_val", tohost, 32'h1);
    wr(TOHOST, 32'h0000_AB00, 4'h2);
    check("halt_sticky", halt, 1);
    check("tohost_lanes", tohost, 32'h0000_AB01);
    do_reset();
    check("halt_cleared", halt, 0);
    check("tohost_cleared", tohost, 0);

    // ---- timer compare ----
    do_reset();
    rd(MTIME_LO, r);
    check("mtime_reset", r, 32'd0);
    wr(CMP_HI, 32'h0, 4'hF);
    wr(CMP_LO, 32'd40, 4'hF);
    repeat (38) tick();
    rd(MTIME_LO, r);
    check("mtime_at_40", r, 32'd40);
    check("irq_not_yet", timer_irq, 0);
    tick();
    rd(MTIME_LO, r);
    check("mtime_at_41", r, 32'd41);
    check("irq_rises", timer_irq, 1);

    wr(MTIME_LO, 32'h0, 4'hF);
    rd(MTIME_LO, r);
    check("mtime_rewritten", r, 32'd0);
    check("irq_still_high", timer_irq, 1);
    tick();
    check("irq_drops", timer_irq, 0);

    // ---- mtime wrap ----
    wr(MTIME_HI, 32'hFFFF_FFFF, 4'hF);
    wr(MTIME_LO, 32'hFFFF_FFFF, 4'hF);
    rd(MTIME_LO, r);
    check("preload_lo", r, 32'hFFFF_FFFF);
    rd(MTIME_HI, r);
    check("preload_hi", r, 32'hFFFF_FFFF);
    tick();
    rd(MTIME_LO, r);
    check("wrap_lo", r, 32'h0);
    rd(MTIME_HI, r);
    check("wrap_hi", r, 32'h0);
    wr(MTIME_LO, 32'h0000_AB00, 4'h2);
    rd(MTIME_LO, r);
    check("mtime_lane_write", r, 32'h0000_AB01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
